// File: rtl/counter_seq_pkg.sv
// counter_sequencer shared types and constants.
// State encoding doubles as the phase output.
package counter_seq_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int REP_W_DEF = 4;

  localparam logic [1:0] PHASE_IDLE  = 2'b00;
  localparam logic [1:0] PHASE_RUN   = 2'b01;
  localparam logic [1:0] PHASE_PAUSE = 2'b10;
  localparam logic [1:0] PHASE_DONE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = PHASE_IDLE,
    ST_RUN   = PHASE_RUN,
    ST_PAUSE = PHASE_PAUSE,
    ST_DONE  = PHASE_DONE
  } state_e;

endpackage

// File: rtl/counter_sequencer_core.sv
// Enable-gated up-counter, synchronous clear.
// Clear wins over enable; wraps modulo 2^WIDTH.
module counter_core
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// Run/pause sequencer driving one counter_core.
// Outputs decode from registered state only.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] run_len,
  input  logic [WIDTH-1:0] pause_len,
  input  logic [REP_W-1:0] repeat_cnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       phase,
  output logic             cnt_en,
  output logic [WIDTH-1:0] count,
  output logic [REP_W-1:0] rep_left
);

  state_e           state_q;
  logic [WIDTH-1:0] run_q;
  logic [WIDTH-1:0] pause_q;
  logic [WIDTH-1:0] pt_q;
  logic [REP_W-1:0] rep_q;

  logic core_en;
  logic core_clr;
  logic run_last;
  logic pause_last;
  logic rep_zero;

  counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (core_en),
    .clr   (core_clr),
    .count (count)
  );

  assign run_last   = (count == run_q - WIDTH'(1));
  assign pause_last = (pt_q == pause_q - WIDTH'(1));
  assign rep_zero   = (rep_q == '0);

  // counter control for the coming edge
  always_comb begin
    core_en  = 1'b0;
    core_clr = 1'b0;
    if (!abort) begin
      unique case (state_q)
        ST_IDLE:  core_clr = start;
        ST_RUN: begin
          if (run_last) begin
            core_clr = !rep_zero
                    && (pause_q == '0);
          end else begin
            core_en = 1'b1;
          end
        end
        ST_PAUSE: core_clr = pause_last;
        default: ;
      endcase
    end
  end

  // sequencer FSM, config latch, pause timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
      pause_q <= '0;
      pt_q    <= '0;
      rep_q   <= '0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      rep_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            run_q   <= run_len;
            pause_q <= pause_len;
            rep_q   <= repeat_cnt;
            state_q <= (run_len != '0)
                     ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (run_last) begin
            if (rep_zero) begin
              state_q <= ST_DONE;
            end else if (pause_q == '0) begin
              rep_q <= rep_q - REP_W'(1);
            end else begin
              state_q <= ST_PAUSE;
              pt_q    <= '0;
            end
          end
        end
        ST_PAUSE: begin
          if (pause_last) begin
            state_q <= ST_RUN;
            rep_q   <= rep_q - REP_W'(1);
          end else begin
            pt_q <= pt_q + WIDTH'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign phase    = state_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign cnt_en   = (state_q == ST_RUN);
  assign rep_left = rep_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomized bench for counter_sequencer.
// Expected traces are built pass by pass.
module tb_counter_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] run_len;
  logic [7:0] pause_len;
  logic [3:0] repeat_cnt;
  logic       busy;
  logic       done;
  logic [1:0] phase;
  logic       cnt_en;
  logic [7:0] count;
  logic [3:0] rep_left;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] ph;
    logic [7:0] cnt;
    logic [3:0] rep;
  } ent_t;

  ent_t       tr[$];
  logic [7:0] last_cnt;
  logic [3:0] last_rep;

  counter_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .run_len    (run_len),
    .pause_len  (pause_len),
    .repeat_cnt (repeat_cnt),
    .busy       (busy),
    .done       (done),
    .phase      (phase),
    .cnt_en     (cnt_en),
    .count      (count),
    .rep_left   (rep_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(
    input logic [1:0] ph,
    input logic [7:0] c,
    input logic [3:0] r);
    logic en, bz, dn;
    en = (ph == 2'b01);
    bz = (ph != 2'b00);
    dn = (ph == 2'b11);
    return {15'd0, ph, en, bz, dn, r, c};
  endfunction

  function automatic logic [31:0] obs();
    return {15'd0, phase, cnt_en, busy, done,
            rep_left, count};
  endfunction

  // expected per-cycle trace of one command
  function automatic void build(input int r,
                                input int p,
                                input int k);
    tr.delete();
    if (r == 0) begin
      tr.push_back('{2'b11, 8'd0, 4'(k)});
    end else begin
      for (int ps = 0; ps <= k; ps++) begin
        for (int i = 0; i < r; i++)
          tr.push_back('{2'b01, 8'(i), 4'(k - ps)});
        if (ps < k)
          for (int j = 0; j < p; j++)
            tr.push_back('{2'b10, 8'(r - 1),
                           4'(k - ps)});
      end
      tr.push_back('{2'b11, 8'(r - 1), 4'd0});
    end
  endfunction

  task automatic run_cmd(input int r, input int p,
                         input int k, input int poke,
                         input int ab);
    build(r, p, k);
    @(negedge clk);
    run_len    = 8'(r);
    pause_len  = 8'(p);
    repeat_cnt = 4'(k);
    start      = 1'b1;
    abort      = 1'b0;
    for (int i = 0; i < tr.size(); i++) begin
      @(negedge clk);
      chk("seq", obs(),
          mk(tr[i].ph, tr[i].cnt, tr[i].rep));
      start      = (i == poke);
      run_len    = 8'($urandom);
      pause_len  = 8'($urandom);
      repeat_cnt = 4'($urandom);
      last_cnt   = tr[i].cnt;
      last_rep   = tr[i].rep;
      if (i == ab) begin
        abort = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        start    = 1'b0;
        last_rep = 4'd0;
        chk("abort", obs(),
            mk(2'b00, last_cnt, last_rep));
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("idle", obs(), mk(2'b00, last_cnt, last_rep));
  endtask

  initial begin
    int r, p, k, len, poke, ab;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    run_len    = '0;
    pause_len  = '0;
    repeat_cnt = '0;
    last_cnt   = '0;
    last_rep   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("reset", obs(), 32'd0);
    end

    run_cmd(3, 2, 1, -1, -1);
    run_cmd(4, 0, 2, -1, -1);
    run_cmd(0, 3, 0, -1, -1);
    run_cmd(0, 2, 5, -1, -1);
    run_cmd(3, 2, 1, 1, -1);
    run_cmd(3, 2, 1, -1, 3);

    @(negedge clk);
    start   = 1'b1;
    abort   = 1'b1;
    run_len = 8'd5;
    repeat (3) begin
      @(negedge clk);
      chk("st_ab", obs(),
          mk(2'b00, last_cnt, last_rep));
    end
    start = 1'b0;
    abort = 1'b0;

    run_cmd(255, 0, 0, 100, -1);

    @(negedge clk);
    run_len    = 8'd10;
    pause_len  = 8'd0;
    repeat_cnt = 4'd2;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst", obs(), mk(2'b01, 8'd3, 4'd2));
    #2 rst_n = 1'b0;
    #1 chk("async_rst", obs(), 32'd0);
    @(negedge clk);
    chk("in_rst", obs(), 32'd0);
    rst_n    = 1'b1;
    last_cnt = '0;
    last_rep = '0;
    run_cmd(5, 1, 1, -1, -1);

    for (int n = 0; n < 25; n++) begin
      r   = $urandom_range(0, 9);
      p   = $urandom_range(0, 4);
      k   = $urandom_range(0, 3);
      len = (r == 0) ? 1
          : (k + 1) * r + k * p + 1;
      poke = $urandom_range(0, len - 1);
      ab   = ($urandom_range(0, 3) == 0)
           ? $urandom_range(0, len - 1) : -1;
      run_cmd(r, p, k, poke, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
